// File: rtl/btn_conditioner.sv
// PunchZombie button front end: sync, debounce, one-shot,
// press arbitration with post-hit lockout, and game tick strobe.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCKOUT_CYCLES  = 8,
  parameter int TICK_DIV        = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic btn1_raw,
  input  logic btn2_raw,
  input  logic btn3_raw,
  output logic btn1,
  output logic btn2,
  output logic btn3,
  output logic btn1_pulse,
  output logic btn2_pulse,
  output logic btn3_pulse,
  output logic multi_press,
  output logic tick
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam int TW = $clog2(TICK_DIV);

  localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_INIT = LW'(LOCKOUT_CYCLES);
  localparam logic [TW-1:0] TICK_MAX  = TW'(TICK_DIV - 1);

  logic [2:0]         raw;
  logic [2:0]         s1_q, s1_d;
  logic [2:0]         s2_q, s2_d;
  logic [2:0]         lvl_q, lvl_d;
  logic [2:0][CW-1:0] cnt_q, cnt_d;
  logic [2:0]         rise;
  logic [2:0]         pulse_q, pulse_d;
  logic               multi_q, multi_d;
  logic [LW-1:0]      lock_q, lock_d;
  logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
  logic               tick_q, tick_d;

  assign raw = {btn3_raw, btn2_raw, btn1_raw};

  // Two-flop synchroniser per button
  always_comb begin
    s1_d = raw;
    s2_d = s1_q;
  end

  // Debounce: flip the level after DEBOUNCE_CYCLES straight disagreements
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    rise  = '0;
    for (int i = 0; i < 3; i++) begin
      if (s2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          lvl_d[i] = s2_q[i];
          rise[i]  = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Arbitrate candidate presses; any accepted strobe arms the lockout
  always_comb begin
    pulse_d = '0;
    multi_d = 1'b0;
    lock_d  = lock_q;
    if (lock_q != '0) begin
      lock_d = lock_q - LW'(1);
    end else if (rise != '0) begin
      lock_d = LOCK_INIT;
      if ($onehot(rise)) begin
        pulse_d = rise;
      end else begin
        multi_d = 1'b1;
      end
    end
  end

  // Free-running tick divider, strobe one cycle after the wrap value
  always_comb begin
    tick_d = (tick_cnt_q == TICK_MAX);
    if (tick_cnt_q == TICK_MAX) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + TW'(1);
    end
  end

  // State registers, all cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q       <= '0;
      s2_q       <= '0;
      lvl_q      <= '0;
      cnt_q      <= '0;
      pulse_q    <= '0;
      multi_q    <= 1'b0;
      lock_q     <= '0;
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      lvl_q      <= lvl_d;
      cnt_q      <= cnt_d;
      pulse_q    <= pulse_d;
      multi_q    <= multi_d;
      lock_q     <= lock_d;
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
    end
  end

  assign btn1        = lvl_q[0];
  assign btn2        = lvl_q[1];
  assign btn3        = lvl_q[2];
  assign btn1_pulse  = pulse_q[0];
  assign btn2_pulse  = pulse_q[1];
  assign btn3_pulse  = pulse_q[2];
  assign multi_press = multi_q;
  assign tick        = tick_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Randomised bench for btn_conditioner against a
// window-based behavioural model of the button pipeline.
module tb_btn_conditioner;

  localparam int D = 4;
  localparam int L = 8;
  localparam int T = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] raw;
  logic       btn1, btn2, btn3;
  logic       btn1_pulse, btn2_pulse, btn3_pulse;
  logic       multi_press, tick;
  logic [7:0] outs;

  always #5 clk = ~clk;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .LOCKOUT_CYCLES (L),
    .TICK_DIV       (T)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn1_raw   (raw[0]),
    .btn2_raw   (raw[1]),
    .btn3_raw   (raw[2]),
    .btn1       (btn1),
    .btn2       (btn2),
    .btn3       (btn3),
    .btn1_pulse (btn1_pulse),
    .btn2_pulse (btn2_pulse),
    .btn3_pulse (btn3_pulse),
    .multi_press(multi_press),
    .tick       (tick)
  );

  assign outs = {tick, multi_press, btn3_pulse, btn2_pulse,
                 btn1_pulse, btn3, btn2, btn1};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: edge index since reset, raw delayed two
  // edges, window of samples since the last level flip.
  int       e;
  bit       sy1 [3];
  bit       sy2 [3];
  bit       lvl [3];
  bit       win [3][$];
  int       lock_until;
  bit [2:0] exp_pulse;
  bit       exp_multi;
  bit       exp_tick;

  function automatic logic [7:0] exp_vec();
    return {exp_tick, exp_multi, exp_pulse[2], exp_pulse[1],
            exp_pulse[0], lvl[2], lvl[1], lvl[0]};
  endfunction

  task automatic model_reset();
    e = 0;
    lock_until = 0;
    exp_pulse = '0;
    exp_multi = 1'b0;
    exp_tick = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sy1[i] = 1'b0;
      sy2[i] = 1'b0;
      lvl[i] = 1'b0;
      win[i].delete();
    end
  endtask

  task automatic model_step(input logic [2:0] r);
    bit [2:0] rises;
    bit       s;
    bit       flip;
    e++;
    rises = '0;
    for (int i = 0; i < 3; i++) begin
      s = sy2[i];
      sy2[i] = sy1[i];
      sy1[i] = r[i];
      win[i].push_back(s);
      if (win[i].size() > D) void'(win[i].pop_front());
      flip = (win[i].size() == D);
      for (int j = 0; j < win[i].size(); j++)
        if (win[i][j] == lvl[i]) flip = 1'b0;
      if (flip) begin
        lvl[i] = ~lvl[i];
        rises[i] = lvl[i];
        win[i].delete();
      end
    end
    exp_pulse = '0;
    exp_multi = 1'b0;
    if (rises != '0 && e >= lock_until) begin
      if ($countones(rises) == 1) exp_pulse = rises;
      else exp_multi = 1'b1;
      lock_until = e + L + 1;
    end
    exp_tick = (e % T == 0);
  endtask

  // Stimulus: random hold lengths, short ones give bounce
  int       hold [3];
  logic [2:0] val;

  task automatic next_raw(input int phase);
    if (phase == 2) begin
      if (hold[0] == 0) begin
        val = 3'($urandom);
        hold[0] = $urandom_range(8, 20);
      end else begin
        hold[0]--;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (hold[i] == 0) begin
          val[i] = 1'($urandom);
          hold[i] = (phase == 0) ? $urandom_range(0, 10)
                                 : $urandom_range(5, 20);
        end else begin
          hold[i]--;
        end
      end
    end
    raw = val;
  endtask

  task automatic do_reset();
    val[0] = 1'b1;
    hold[0] = 40;
    raw = val;
    #2 rst = 1'b1;
    #1 check("async_rst", outs, 8'h00);
    @(negedge clk);
    check("rst_hold", outs, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  bit did_lock_rst = 1'b0;

  initial begin
    rst = 1'b1;
    raw = '0;
    val = '0;
    hold = '{0, 0, 0};
    model_reset();
    repeat (3) @(negedge clk);
    check("reset", outs, 8'h00);
    rst = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      next_raw((cyc / 150) % 3);
      model_step(raw);
      @(negedge clk);
      check("outs", outs, exp_vec());
      check("one_strobe", 8'($countones(outs[6:3]) <= 1), 8'd1);
      if (cyc == 1200) begin
        do_reset();
      end else if (cyc > 1800 && !did_lock_rst &&
                   e < lock_until - 1 && lvl[0]) begin
        did_lock_rst = 1'b1;
        do_reset();
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
